// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a shared UART transmitter: grants one byte producer at a time,
// launches the frame, acknowledges on completion and aborts via watchdog on a hung frame.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [NREQ-1:0]   LOCK,
  input  logic [8*NREQ-1:0] DATA_IN,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   ACK,
  output logic              ERR,
  output logic [7:0]        TX_DATA,
  output logic              TX_START,
  input  logic              TX_BUSY,
  input  logic              TX_DONE
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_TERM = WW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, FIN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   own_q, own_d;
  logic            held_q, held_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            err_q, err_d;
  logic            start_q, start_d;
  logic [7:0]      data_q, data_d;

  logic            found;
  logic [PW-1:0]   rr_win;
  logic            relock;
  logic [PW-1:0]   nxt;
  logic [7:0]      nxt_data;
  int unsigned     idx;

  // First requester at or after the pointer, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    rr_win = '0;
    idx    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && REQ[idx]) begin
        found  = 1'b1;
        rr_win = PW'(idx);
      end
    end
  end

  assign relock = held_q && REQ[own_q] && LOCK[own_q];
  assign nxt    = relock ? own_q : rr_win;

  always_comb begin
    nxt_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (PW'(k) == nxt) nxt_data = DATA_IN[8*k +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    held_d  = held_q;
    wd_d    = wd_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    ack_d   = '0;
    err_d   = 1'b0;
    start_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        held_d = 1'b0;
        gnt_d  = '0;
        if (relock || found) begin
          own_d      = nxt;
          gnt_d[nxt] = 1'b1;
          data_d     = nxt_data;
          state_d    = START;
        end
      end
      START: begin
        if (!TX_BUSY) begin
          start_d = 1'b1;
          wd_d    = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (TX_DONE) begin
          ack_d[own_q] = 1'b1;
          state_d      = FIN;
        end else if (wd_q == WD_TERM) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      FIN: begin
        // err_q is high exactly during the FIN that follows an abort.
        if (LOCK[own_q] && !err_q) begin
          held_d = 1'b1;
        end else begin
          ptr_d = (own_q == PTR_LAST) ? '0 : own_q + 1'b1;
          gnt_d = '0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      held_q  <= 1'b0;
      wd_q    <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      held_q  <= held_d;
      wd_q    <= wd_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

  assign GNT      = gnt_q;
  assign ACK      = ack_q;
  assign ERR      = err_q;
  assign TX_START = start_q;
  assign TX_DATA  = data_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter between `NREQ` byte producers on the 12 MHz system clock (9600 baud, 8N1, 1250 clocks/bit, 12500 clocks/frame). It grants one requester at a time and latches its byte. It launches the transmitter, waits for frame completion, then acknowledges the requester. A per-requester LOCK keeps the grant across back-to-back bytes for packets, and a watchdog recovers from a transmitter that never finishes.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 15000: clocks allowed from `TX_START` to `TX_DONE` before abort.
- `CLK` in 1: system clock, 12 MHz.
- `RST` in 1: synchronous, active-low reset.
- `REQ` in NREQ: request, bit i for requester i. Held high with data stable until ACK[i] or ERR.
- `LOCK` in NREQ: requester i asks to keep its grant after its current byte.
- `DATA_IN` in 8*NREQ: requester i byte at [8i+7:8i].
- `GNT` out NREQ: one-hot current owner, all-zero when idle.
- `ACK` out NREQ: one-cycle pulse, byte of owner fully transmitted.
- `ERR` out 1: one-cycle pulse, watchdog abort of current owner's byte.
- `TX_DATA` out 8: byte to transmitter, stable from grant until next grant.
- `TX_START` out 1: one-cycle launch pulse to transmitter.
- `TX_BUSY` in 1: transmitter mid-frame.
- `TX_DONE` in 1: transmitter one-cycle end-of-stop-bit pulse.

## Operation
- All outputs are registered.
- Reset (RST=0 at a rising edge) sets state IDLE, GNT=0, ACK=0, ERR=0, TX_START=0, TX_DATA=8'h00, pointer PTR=0, and clears the watchdog.
- Reset mid-frame abandons the frame with no ACK or ERR. The transmitter is reset separately.
- FSM states are IDLE, START, WAIT, FIN.
- IDLE behaviour:
  - If the previous owner o has LOCK[o]=1 and REQ[o]=1, o wins again.
  - Otherwise the winner is the first i with REQ[i]=1 scanning PTR, PTR+1, … mod NREQ.
  - On a winner: GNT<=onehot(winner), TX_DATA<=DATA_IN[winner], state goes to START.
  - With no winner, GNT<=0.
- START behaviour:
  - While TX_BUSY=1, the FSM holds.
  - When TX_BUSY=0: TX_START<=1 for one cycle, watchdog cleared, state goes to WAIT.
- WAIT behaviour:
  - The watchdog increments each cycle.
  - On TX_DONE=1: ACK[owner]<=1 for one cycle, state goes to FIN.
  - Else if the watchdog reaches TIMEOUT-1: ERR<=1 for one cycle, lock is forfeited, state goes to FIN.
  - If TX_DONE and timeout occur in the same cycle, TX_DONE wins (ACK, no ERR).
- FIN behaviour:
  - If LOCK[owner]=1 and no ERR, GNT is held and ownership is remembered for IDLE.
  - Otherwise PTR<=owner+1 mod NREQ and GNT<=0.
  - State goes to IDLE.
- REQ deasserted by the owner after grant does not cancel the byte. The frame completes and ACK still pulses.
- LOCK without REQ in IDLE does not stall others: the lock is dropped and round-robin proceeds.
- TX_DONE outside WAIT is ignored. TX_BUSY is sampled only in START.
- After ERR the requester keeps REQ high and is retried at its next round-robin turn.
- Requesters update REQ/DATA_IN on the edge after seeing ACK. IDLE therefore samples post-ACK values.

## Timing
- REQ sampled in IDLE at cycle 0: GNT and TX_DATA are valid in cycle 1 (START).
- With TX_BUSY=0 in cycle 1, TX_START is high in cycle 2.
- ACK is high in the cycle after TX_DONE is high. FIN follows, then IDLE (1 cycle).
- Locked re-grant is at IDLE+1 and its TX_START at IDLE+2. The inter-frame overhead is 4 clocks plus the transmitter gap.
- ERR is high TIMEOUT cycles after TX_START is high.
- The watchdog counter is ceil(log2(TIMEOUT)) bits wide and does not wrap.
- PTR is ceil(log2(NREQ)) bits and wraps NREQ-1 to 0.

## Test plan
- Reset:
  - Stimulus: hold RST=0 for 3 cycles with REQ=4'b1111.
  - Expected: all outputs 0 and no TX_START. After release, requester 0 is granted first (GNT=4'b0001), TX_DATA=DATA_IN[7:0], and TX_START 2 cycles after release.
- Round-robin:
  - Stimulus: REQ=4'b1111, LOCK=0, transmitter model with 12500-clock frames. Bytes are 8'h66, 8'h77, 8'hA5, 8'h3C.
  - Expected: grants 0,1,2,3,0 in order, each ACK one cycle after TX_DONE, and TX_DATA matching each requester's byte.
- Lock:
  - Stimulus: requester 2 has LOCK=1 for 3 bytes (8'h66, 8'h77, 8'h12) while requesters 0 and 1 request.
  - Expected: GNT=4'b0100 is continuous across all 3 frames. Requester 0 is granted immediately after requester 2's LOCK drops, since PTR=3 wraps to 0.
- Busy hold:
  - Stimulus: TX_BUSY=1 during START for 100 cycles.
  - Expected: TX_START is delayed until the cycle after TX_BUSY falls, and GNT stays stable throughout.
- Timeout:
  - Stimulus: TIMEOUT=200 and the model never pulses TX_DONE.
  - Expected: ERR pulses exactly 200 cycles after TX_START, with no ACK. The next requester is granted, and the failed requester is retried on its turn.
- Simultaneous events:
  - Stimulus: TX_DONE arrives in the same cycle as the watchdog terminal count.
  - Expected: ACK only, with no ERR. Separately, TX_DONE pulsed in IDLE produces no ACK.
